synaptic_update_sequencer: RTL

Drives the synaptic-core memory ports during the weight-update phase of training. On a start pulse it walks every (pre-neuron, post-word) pair of the synaptic and gradient SRAMs in a read-wait-write sequence, presenting pre/post neuron addresses so spike counts align with SRAM read data at `ffstdp_update`. Sits directly upstream of `synaptic_core`, between the top-level training FSM and the core's `CTRL_*` inputs.

---
 rtl/snn_ff_pkg.sv | 26 ++
 rtl/syn_row_word_counter.sv | 64 ++++++
 rtl/synaptic_update_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/snn_ff_pkg.sv
// Shared definitions for the synaptic update sequencer: FSM state encoding,
// SRAM row geometry and the read-to-write latency floor.
package snn_ff_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_FIN,
    ST_PRE_FETCH,
    ST_PRE_CHK
  } seq_state_t;

  localparam int UPDATE_LAT_MIN = 1;

  function automatic int syn_words(input int out_neurons, input int parallel);
    return out_neurons / parallel;
  endfunction

  // A write-back can never share the cycle of its own read strobe.
  function automatic int update_lat_floor(input int lat);
    return (lat < UPDATE_LAT_MIN) ? UPDATE_LAT_MIN : lat;
  endfunction

endpackage

// File: rtl/syn_row_word_counter.sv
// Row/word walker for the synaptic SRAM: keeps the linear word address and the
// first post-neuron index of the current word by incrementing, never multiplying.
module syn_row_word_counter
  import snn_ff_pkg::*;
#(
  parameter int INPUT_NEURON         = 784,
  parameter int OUTPUT_NEURON        = 256,
  parameter int POST_NEUR_PARALLEL   = 4,
  parameter int PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int POST_NEUR_ADDR_WIDTH = 10,
  parameter int SYN_ARRAY_ADDR_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            adv,
  input  logic                            skip_row,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0]  row,
  output logic [POST_NEUR_ADDR_WIDTH-1:0] post,
  output logic [SYN_ARRAY_ADDR_WIDTH-1:0] addr,
  output logic                            last_word,
  output logic                            last_row
);

  localparam int SYN_WORDS = syn_words(OUTPUT_NEURON, POST_NEUR_PARALLEL);
  localparam logic [POST_NEUR_ADDR_WIDTH-1:0] LAST_WORD = POST_NEUR_ADDR_WIDTH'(SYN_WORDS - 1);
  localparam logic [PRE_NEUR_ADDR_WIDTH-1:0]  LAST_ROW  = PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1);
  localparam logic [POST_NEUR_ADDR_WIDTH-1:0] POST_STEP = POST_NEUR_ADDR_WIDTH'(POST_NEUR_PARALLEL);
  localparam logic [SYN_ARRAY_ADDR_WIDTH-1:0] ROW_STEP  = SYN_ARRAY_ADDR_WIDTH'(SYN_WORDS);

  logic [POST_NEUR_ADDR_WIDTH-1:0] word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      word <= '0;
      post <= '0;
      addr <= '0;
    end else if (clr) begin
      row  <= '0;
      word <= '0;
      post <= '0;
      addr <= '0;
    end else if (adv) begin
      addr <= addr + 1'b1;
      if (last_word) begin
        word <= '0;
        post <= '0;
        row  <= row + 1'b1;
      end else begin
        word <= word + 1'b1;
        post <= post + POST_STEP;
      end
    end else if (skip_row) begin
      // Only taken at word 0, so a whole row of words is jumped.
      row  <= row + 1'b1;
      addr <= addr + ROW_STEP;
    end
  end

  assign last_word = (word == LAST_WORD);
  assign last_row  = (row == LAST_ROW);

endmodule

// File: rtl/synaptic_update_sequencer.sv
// Weight-update sequencer: read-wait-write walk over every (row, word) of the
// synaptic/gradient SRAMs. Define SYN_UPDATE_SKIP_ZERO_PRE_EN to skip rows whose pre spike count is zero.
module synaptic_update_sequencer
  import snn_ff_pkg::*;
#(
  parameter int INPUT_NEURON         = 784,
  parameter int OUTPUT_NEURON        = 256,
  parameter int POST_NEUR_PARALLEL   = 4,
  parameter int PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int POST_NEUR_ADDR_WIDTH = 10,
  parameter int SYN_ARRAY_ADDR_WIDTH = 16,
  parameter int UPDATE_LAT           = 1,
  parameter int PRE_NEUR_DATA_WIDTH  = 8
) (
  input  logic                            CLK,
  input  logic                            RSTN,
  input  logic                            START,
  input  logic                            IS_TRAIN,
  input  logic [PRE_NEUR_DATA_WIDTH-1:0]  PRE_NEUR_S_CNT,
  output logic                            BUSY,
  output logic                            DONE,
  output logic                            CTRL_SYNARRAY_CS,
  output logic                            CTRL_SYNARRAY_WE,
  output logic                            CTRL_GRAD_ARRAY_CS,
  output logic                            CTRL_GRAD_ARRAY_WE,
  output logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_SYNARRAY_ADDR,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0]  CTRL_PRE_NEURON_ADDRESS,
  output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
  output logic                            CTRL_TREF_EVENT
);

  localparam int LAT    = update_lat_floor(UPDATE_LAT);
  localparam int WAIT_W = $clog2(LAT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LAT - 1);

`ifdef SYN_UPDATE_SKIP_ZERO_PRE_EN
  localparam seq_state_t ROW_ENTRY = ST_PRE_FETCH;
`else
  localparam seq_state_t ROW_ENTRY = ST_READ;
  logic unused_s_cnt;
  assign unused_s_cnt = ^PRE_NEUR_S_CNT;
`endif

  seq_state_t        state, state_d;
  logic [WAIT_W-1:0] wait_cnt, wait_d;
  logic              clr, adv, skip_row, last_word, last_row;
  logic              cs_q, we_q, busy_q, done_q;

  syn_row_word_counter #(
    .INPUT_NEURON         (INPUT_NEURON),
    .OUTPUT_NEURON        (OUTPUT_NEURON),
    .POST_NEUR_PARALLEL   (POST_NEUR_PARALLEL),
    .PRE_NEUR_ADDR_WIDTH  (PRE_NEUR_ADDR_WIDTH),
    .POST_NEUR_ADDR_WIDTH (POST_NEUR_ADDR_WIDTH),
    .SYN_ARRAY_ADDR_WIDTH (SYN_ARRAY_ADDR_WIDTH)
  ) u_counter (
    .clk       (CLK),
    .rst_n     (RSTN),
    .clr       (clr),
    .adv       (adv),
    .skip_row  (skip_row),
    .row       (CTRL_PRE_NEURON_ADDRESS),
    .post      (CTRL_POST_NEURON_ADDRESS),
    .addr      (CTRL_SYNARRAY_ADDR),
    .last_word (last_word),
    .last_row  (last_row)
  );

  always_comb begin
    state_d  = state;
    wait_d   = wait_cnt;
    clr      = 1'b0;
    adv      = 1'b0;
    skip_row = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          if (IS_TRAIN) begin
            clr     = 1'b1;
            state_d = ROW_ENTRY;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_READ: begin
        if (LAT > 1) begin
          state_d = ST_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_d = ST_WRITE;
        else                       wait_d  = wait_cnt + 1'b1;
      end
      ST_WRITE: begin
        if (last_word && last_row) begin
          state_d = ST_FIN;
        end else begin
          adv     = 1'b1;
          state_d = last_word ? ROW_ENTRY : ST_READ;
        end
      end
      ST_FIN: state_d = ST_IDLE;
`ifdef SYN_UPDATE_SKIP_ZERO_PRE_EN
      ST_PRE_FETCH: state_d = ST_PRE_CHK;
      ST_PRE_CHK: begin
        if (PRE_NEUR_S_CNT != '0) begin
          state_d = ST_READ;
        end else if (last_row) begin
          state_d = ST_FIN;
        end else begin
          skip_row = 1'b1;
          state_d  = ST_PRE_FETCH;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they appear with the state itself.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
      cs_q     <= (state_d == ST_READ) || (state_d == ST_WRITE);
      we_q     <= (state_d == ST_WRITE);
      busy_q   <= (state_d != ST_IDLE) && (state_d != ST_FIN);
      done_q   <= (state_d == ST_FIN);
    end
  end

  assign CTRL_SYNARRAY_CS   = cs_q;
  assign CTRL_SYNARRAY_WE   = we_q;
  assign CTRL_GRAD_ARRAY_CS = cs_q;
  assign CTRL_GRAD_ARRAY_WE = we_q;
  assign BUSY               = busy_q;
  assign CTRL_TREF_EVENT    = busy_q;
  assign DONE               = done_q;

endmodule
